// File: rtl/reg_file_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package reg_file_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 3;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, emitting a zero-write strobe/address.
module rf_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int AW = RF_AW
)(
    input  logic          clk,
    input  logic          i_reset,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    rf_state_t     r_state;
    rf_state_t     w_state_next;
    logic [AW-1:0] r_clr_ptr;
    logic [AW-1:0] w_ptr_next;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state   <= RF_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_clr_ptr;
        case (r_state)
            RF_CLEAR: begin
                // The pointer wraps naturally back to 0 on the last entry.
                w_ptr_next = r_clr_ptr + AW'(1);
                if (r_clr_ptr == {AW{1'b1}}) begin
                    w_state_next = RF_IDLE;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    assign o_busy     = (r_state == RF_CLEAR);
    // A reset edge restarts the walk and must not write the array.
    assign o_clr_we   = o_busy && !i_reset;
    assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised 2-write/2-read register file with self-clearing after reset.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int AW       = RF_AW,
    parameter int ZERO_REG = 0
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          wr2_en,
    input  logic [AW-1:0] wr2_addr,
    input  logic [DW-1:0] dat2_in,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_we0;
    logic          w_we1;
    logic [DW-1:0] r_core [DEPTH];
    logic [AW-1:0] w_rd_addr [2];
    logic [DW-1:0] w_rd_dat [2];

    rf_clear_ctrl #(.AW(AW)) u_clear (
        .clk        (clk),
        .i_reset    (reset),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Effective user writes: blocked by reset, by the clear walk and by a hardwired entry 0.
    assign w_we0 = wr_en  && !w_busy && !reset && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign w_we1 = wr2_en && !w_busy && !reset && !((ZERO_REG != 0) && (wr2_addr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_clr_we && (w_clr_addr == AW'(gi))) begin
                    r_core[gi] <= '0;
                end else if (w_we0 && (wr_addr == AW'(gi))) begin
                    r_core[gi] <= dat_in;
                end else if (w_we1 && (wr2_addr == AW'(gi))) begin
                    r_core[gi] <= dat2_in;
                end
            end
        end
    endgenerate

    assign w_rd_addr[0] = rd_addrA;
    assign w_rd_addr[1] = rd_addrB;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                w_rd_dat[gi] = r_core[w_rd_addr[gi]];
`ifdef REG_FILE_BYPASS_EN
                // Port 0 is checked last so it wins, matching write priority.
                if (w_we1 && (wr2_addr == w_rd_addr[gi])) begin
                    w_rd_dat[gi] = dat2_in;
                end
                if (w_we0 && (wr_addr == w_rd_addr[gi])) begin
                    w_rd_dat[gi] = dat_in;
                end
`endif
                if (w_busy || ((ZERO_REG != 0) && (w_rd_addr[gi] == '0))) begin
                    w_rd_dat[gi] = '0;
                end
            end
        end
    endgenerate

    assign datA_out = w_rd_dat[0];
    assign datB_out = w_rd_dat[1];
    assign busy     = w_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector tables plus randomized traffic
// against a behavioural model, on a default instance and a ZERO_REG=1 instance.
module tb_reg_file_mp;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit         rst;
        bit         we;
        logic [2:0] wa;
        logic [7:0] wd;
        bit         we2;
        logic [2:0] wa2;
        logic [7:0] wd2;
        logic [2:0] ra;
        logic [2:0] rb;
        bit         chk;
        logic [7:0] ea;
        logic [7:0] eb;
        bit         ebusy;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       wr_en, wr2_en;
    logic [2:0] wr_addr, wr2_addr, rd_addrA, rd_addrB;
    logic [7:0] dat_in, dat2_in;
    logic [7:0] d0A, d0B, dzA, dzB;
    logic       b0, bz;

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model: per instance, contents and remaining clear cycles.
    logic [7:0] m_mem [2][8];
    int         m_busy_left [2];
    bit         m_init = 1'b0;

    reg_file_mp #(.DW(8), .AW(3), .ZERO_REG(0)) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .wr2_en(wr2_en), .wr2_addr(wr2_addr), .dat2_in(dat2_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(d0A), .datB_out(d0B), .busy(b0)
    );

    reg_file_mp #(.DW(8), .AW(3), .ZERO_REG(1)) u_dutz (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .wr2_en(wr2_en), .wr2_addr(wr2_addr), .dat2_in(dat2_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(dzA), .datB_out(dzB), .busy(bz)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(bit rst, bit we, logic [2:0] wa, logic [7:0] wd,
                                bit we2, logic [2:0] wa2, logic [7:0] wd2,
                                logic [2:0] ra, logic [2:0] rb, bit chk,
                                logic [7:0] ea, logic [7:0] eb, bit ebusy);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
        v.we2 = we2; v.wa2 = wa2; v.wd2 = wd2;
        v.ra = ra; v.rb = rb; v.chk = chk;
        v.ea = ea; v.eb = eb; v.ebusy = ebusy;
        return v;
    endfunction

    // Expected read value for instance d (1 = zero-register instance) at the current inputs.
    function automatic logic [7:0] exp_rd(int d, logic [2:0] a);
        if (m_busy_left[d] > 0) return 8'h00;
        if (d == 1 && a == 3'd0) return 8'h00;
        if (BYP && !reset) begin
            if (wr_en  && wr_addr  == a) return dat_in;
            if (wr2_en && wr2_addr == a) return dat2_in;
        end
        return m_mem[d][a];
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy_left[d] = 8;
            end else if (m_busy_left[d] > 0) begin
                m_busy_left[d]--;
                if (m_busy_left[d] == 0) begin
                    for (int k = 0; k < 8; k++) m_mem[d][k] = 8'h00;
                end
            end else begin
                if (wr2_en && !(d == 1 && wr2_addr == 3'd0)) m_mem[d][wr2_addr] = dat2_in;
                if (wr_en  && !(d == 1 && wr_addr  == 3'd0)) m_mem[d][wr_addr]  = dat_in;
            end
        end
        if (reset) m_init = 1'b1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance model at the rising edge.
    // tgt selects the instance checked against the vector's own expectations (-1: model only).
    task automatic step(input vec_t v, input int tgt, input string tag);
        logic [7:0] act_a, act_b, ex_a, ex_b;
        logic       act_bz, ex_bz;
        reset = v.rst;
        wr_en = v.we;   wr_addr = v.wa;   dat_in = v.wd;
        wr2_en = v.we2; wr2_addr = v.wa2; dat2_in = v.wd2;
        rd_addrA = v.ra; rd_addrB = v.rb;
        @(negedge clk);
        $display("%s rst=%0b w0=%0b@%0d:%h w1=%0b@%0d:%h rA=%0d rB=%0d | u0 %h %h b%0b | uz %h %h b%0b",
                 tag, v.rst, v.we, v.wa, v.wd, v.we2, v.wa2, v.wd2, v.ra, v.rb,
                 d0A, d0B, b0, dzA, dzB, bz);
        if (v.chk) begin
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin act_a = d0A; act_b = d0B; act_bz = b0; end
                else        begin act_a = dzA; act_b = dzB; act_bz = bz; end
                if (d == tgt) begin
                    ex_a = v.ea; ex_b = v.eb; ex_bz = v.ebusy;
                end else begin
                    ex_a = exp_rd(d, v.ra); ex_b = exp_rd(d, v.rb);
                    ex_bz = (m_busy_left[d] > 0);
                end
                if (d == tgt || m_init) begin
                    chk($sformatf("%s u%0d busy", tag, d), {7'd0, act_bz}, {7'd0, ex_bz});
                    chk($sformatf("%s u%0d datA", tag, d), act_a, ex_a);
                    chk($sformatf("%s u%0d datB", tag, d), act_b, ex_b);
                end
            end
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t zs[$];
        vec_t rv;

        // Reset two cycles, then an eight-cycle clear with reads forced to zero.
        tbl.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 3'd0,3'd0, 0, 8'h00,8'h00, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 3'd5,3'd2, 1, 8'h00,8'h00, 1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'(i),3'(7-i), 1, 8'h00,8'h00, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'(2*i),3'(2*i+1), 1, 8'h00,8'h00, 0));
        // Dual write, collision, read-during-write.
        tbl.push_back(mk(0, 1,3'd3,8'hA5, 1,3'd6,8'h3C, 3'd3,3'd6, 1,
                         BYP ? 8'hA5 : 8'h00, BYP ? 8'h3C : 8'h00, 0));
        tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd3,3'd6, 1, 8'hA5,8'h3C, 0));
        tbl.push_back(mk(0, 1,3'd2,8'h11, 1,3'd2,8'h22, 3'd2,3'd2, 1,
                         BYP ? 8'h11 : 8'h00, BYP ? 8'h11 : 8'h00, 0));
        tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd2,3'd2, 1, 8'h11,8'h11, 0));
        tbl.push_back(mk(0, 1,3'd4,8'h5A, 0,0,8'h00, 3'd4,3'd3, 1,
                         BYP ? 8'h5A : 8'h00, 8'hA5, 0));
        tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd4,3'd6, 1, 8'h5A,8'h3C, 0));
        // Reset, restart three cycles into the clear, writes attempted while busy.
        tbl.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 3'd3,3'd4, 1, 8'hA5,8'h5A, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd3,3'd7, 1, 8'h00,8'h00, 1));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 3'd3,3'd7, 1, 8'h00,8'h00, 1));
        tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd3,3'd7, 1, 8'h00,8'h00, 1));
        tbl.push_back(mk(0, 1,3'd7,8'hFF, 0,0,8'h00, 3'd7,3'd7, 1, 8'h00,8'h00, 1));
        tbl.push_back(mk(0, 0,0,8'h00, 1,3'd1,8'hEE, 3'd1,3'd7, 1, 8'h00,8'h00, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd7,3'd1, 1, 8'h00,8'h00, 1));
        tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd7,3'd1, 1, 8'h00,8'h00, 0));
        tbl.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd3,3'd6, 1, 8'h00,8'h00, 0));

        foreach (tbl[i]) step(tbl[i], 0, $sformatf("vec%0d", i));

        // Hardwired entry 0 on the ZERO_REG instance.
        zs.push_back(mk(0, 1,3'd0,8'h77, 0,0,8'h00, 3'd0,3'd0, 1, 8'h00,8'h00, 0));
        zs.push_back(mk(0, 1,3'd1,8'h77, 1,3'd0,8'h77, 3'd0,3'd1, 1,
                        8'h00, BYP ? 8'h77 : 8'h00, 0));
        zs.push_back(mk(0, 0,0,8'h00, 0,0,8'h00, 3'd0,3'd1, 1, 8'h00,8'h77, 0));
        foreach (zs[i]) step(zs[i], 1, $sformatf("zr%0d", i));

        // Randomized traffic with occasional resets, checked against the model.
        for (int n = 0; n < 400; n++) begin
            rv = mk($urandom_range(0, 63) == 0,
                    $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
                    $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1,
                    8'h00, 8'h00, 0);
            step(rv, -1, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
